vga_scanout: RTL

- Read-side (display end) of the 1-bit pixel framebuffer interface; the processor is the write end.
- Generates 640x480@60 VGA timing and walks the framebuffer in raster order.
- Issues a 19-bit pixel address and takes the 1-bit pixel back one clock later from the framebuffer's synchronous read port.
- Drives hSync/vSync and 4-bit R/G/B; sits beside the CPU in the top-level wrapper on the same system clock (50 MHz, divided internally to the pixel rate).

---
 rtl/vga_scanout.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: display-side reader of the 1-bit framebuffer; 640x480@60 timing.
// Ports: clock/reset, pixel_addr/pixel_data (1-clock RAM), hSync/vSync, VGA_R/G/B, frame_start, active.
module vga_scanout #(
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter int          CLK_DIV   = 2,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] pixel_addr,
    input  logic        pixel_data,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        frame_start,
    output logic        active
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // One spare bit so sync end positions equal to the total still fit.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    // CLK_DIV >= 2 is required: the RAM read must land before the next tick.
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [18:0] ADDR_LAST = 19'(H_VISIBLE * V_VISIBLE - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [18:0]   addr_q, addr_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          frame_start_q, frame_start_d;
    logic [11:0]   rgb_q, rgb_d;

    logic tick;
    logic h_end;
    logic v_end;
    logic wrap;
    logic visible;
    logic in_hs;
    logic in_vs;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        h_end   = (h_q == H_LAST);
        v_end   = (v_q == V_LAST);
        wrap    = h_end && v_end;
        visible = (h_q < H_VIS) && (v_q < V_VIS);
        in_hs   = (h_q >= HS_START) && (h_q < HS_END);
        in_vs   = (v_q >= VS_START) && (v_q < VS_END);
    end

    always_comb begin
        div_d         = tick ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        addr_d        = addr_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;

        if (tick) begin
            h_d = h_end ? '0 : h_q + 1'b1;
            if (h_end) begin
                v_d = v_end ? '0 : v_q + 1'b1;
            end

            // Address follows the raster; it parks on the last
            // pixel through vertical blanking until the frame wraps.
            if (wrap) begin
                addr_d = '0;
            end else if (visible && (addr_q != ADDR_LAST)) begin
                addr_d = addr_q + 1'b1;
            end

            // Output stage uses pre-advance counters; pixel_data
            // already holds the word for this position.
            hsync_d       = !in_hs;
            vsync_d       = !in_vs;
            active_d      = visible;
            rgb_d         = visible ? (pixel_data ? FG_COLOR : BG_COLOR)
                                    : 12'h000;
            frame_start_d = wrap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            addr_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            addr_q        <= addr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_addr  = addr_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];

endmodule
